second_largest_arbiter: RTL and testbench

Shares one second-largest compare/update datapath between NUM_CH independent sample streams. Each channel keeps its own running maximum and second-largest value in a register bank. A round-robin arbiter grants at most one channel per cycle. The granted sample updates that channel's bank entry, and the updated pair is reported one cycle later on a single result port. The block sits between the per-lane sample producers and the statistics consumer.

---
 rtl/second_largest_arbiter.sv | 128 ++++++++++++
 tb/tb_second_largest_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/second_largest_arbiter.sv
// Round-robin shared max/second-max tracker for NUM_CH sample streams; result registered one cycle after acceptance.
// Backpressure: o_req_ready grants one valid channel per cycle; result port has no backpressure.
module second_largest_arbiter #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_CH     = 4,
  localparam int CW         = $clog2(NUM_CH)
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [NUM_CH-1:0]            i_req_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_CH-1:0]            o_req_ready,
  input  logic [NUM_CH-1:0]            i_clr,
  output logic                         o_res_valid,
  output logic [CW-1:0]                o_res_ch,
  output logic [DATA_WIDTH-1:0]        o_res_max,
  output logic [DATA_WIDTH-1:0]        o_res_max2,
  output logic                         o_res_max2_ok
);

  logic [DATA_WIDTH-1:0] r_max  [NUM_CH];
  logic [DATA_WIDTH-1:0] r_max2 [NUM_CH];
  logic [1:0]            r_cnt  [NUM_CH];
  logic [CW-1:0]         r_rr;

  logic [DATA_WIDTH-1:0] w_data [NUM_CH];
  logic                  w_grant_any;
  logic [CW-1:0]         w_grant_ch;
  logic [CW-1:0]         w_idx;
  logic [DATA_WIDTH-1:0] w_d;
  logic [DATA_WIDTH-1:0] w_cur_max;
  logic [DATA_WIDTH-1:0] w_cur_max2;
  logic [1:0]            w_cur_cnt;
  logic [DATA_WIDTH-1:0] w_nmax;
  logic [DATA_WIDTH-1:0] w_nmax2;
  logic [1:0]            w_ncnt;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
    assign w_data[c] = i_req_data[c*DATA_WIDTH +: DATA_WIDTH];
  end

  // First valid channel at or after r_rr; grants are suppressed during reset so nothing is consumed.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_ch  = '0;
    w_idx       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = r_rr + CW'(k);
      if (!w_grant_any && !i_reset && i_req_valid[w_idx]) begin
        w_grant_any = 1'b1;
        w_grant_ch  = w_idx;
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (w_grant_any) o_req_ready[w_grant_ch] = 1'b1;
  end

  // A same-cycle clear of the granted channel is seen by the update as an empty entry.
  always_comb begin
    w_d        = w_data[w_grant_ch];
    w_cur_max  = i_clr[w_grant_ch] ? '0    : r_max[w_grant_ch];
    w_cur_max2 = i_clr[w_grant_ch] ? '0    : r_max2[w_grant_ch];
    w_cur_cnt  = i_clr[w_grant_ch] ? 2'd0  : r_cnt[w_grant_ch];
    w_nmax     = w_cur_max;
    w_nmax2    = w_cur_max2;
    w_ncnt     = w_cur_cnt;
    if (w_cur_cnt == 2'd0) begin
      w_nmax  = w_d;
      w_nmax2 = '0;
      w_ncnt  = 2'd1;
    end else if (w_d > w_cur_max) begin
      w_nmax2 = w_cur_max;
      w_nmax  = w_d;
      w_ncnt  = 2'd2;
    end else if (w_d == w_cur_max) begin
      w_ncnt  = w_cur_cnt;
    end else if (w_d > w_cur_max2 || w_cur_cnt == 2'd1) begin
      w_nmax2 = w_d;
      w_ncnt  = 2'd2;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rr <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_max[i]  <= '0;
        r_max2[i] <= '0;
        r_cnt[i]  <= 2'd0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_grant_any && w_grant_ch == CW'(i)) begin
          r_max[i]  <= w_nmax;
          r_max2[i] <= w_nmax2;
          r_cnt[i]  <= w_ncnt;
        end else if (i_clr[i]) begin
          r_max[i]  <= '0;
          r_max2[i] <= '0;
          r_cnt[i]  <= 2'd0;
        end
      end
      if (w_grant_any) r_rr <= w_grant_ch + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_res_valid   <= 1'b0;
      o_res_ch      <= '0;
      o_res_max     <= '0;
      o_res_max2    <= '0;
      o_res_max2_ok <= 1'b0;
    end else begin
      o_res_valid <= w_grant_any;
      if (w_grant_any) begin
        o_res_ch      <= w_grant_ch;
        o_res_max     <= w_nmax;
        o_res_max2    <= w_nmax2;
        o_res_max2_ok <= (w_ncnt == 2'd2);
      end
    end
  end

endmodule

// File: tb/tb_second_largest_arbiter.sv
// Directed and randomized checks of second_largest_arbiter against a distinct-value-set reference model.
module tb_second_largest_arbiter;
  localparam int DW  = 32;
  localparam int NCH = 4;
  localparam int CW  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    req_valid;
  logic [NCH-1:0]    req_ready;
  logic [NCH*DW-1:0] req_data;
  logic [NCH-1:0]    clr;
  logic              res_valid;
  logic [CW-1:0]     res_ch;
  logic [DW-1:0]     res_max;
  logic [DW-1:0]     res_max2;
  logic              res_max2_ok;
  logic [DW-1:0]     din [NCH];

  always #5 clk = ~clk;

  for (genvar c = 0; c < NCH; c++) begin : g_pk
    assign req_data[c*DW +: DW] = din[c];
  end

  second_largest_arbiter #(.DATA_WIDTH(DW), .NUM_CH(NCH)) dut (
    .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(req_ready), .i_clr(clr), .o_res_valid(res_valid), .o_res_ch(res_ch),
    .o_res_max(res_max), .o_res_max2(res_max2), .o_res_max2_ok(res_max2_ok)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: each channel is the set of distinct values seen since reset/clear.
  int            m_rr;
  int            q_ch [$];
  logic [DW-1:0] q_val [$];
  logic          e_vld;
  logic [CW-1:0] e_ch;
  logic [DW-1:0] e_max, e_max2;
  logic          e_ok;

  logic [DW-1:0] seq1 [5] = '{32'd5, 32'd3, 32'd9, 32'd9, 32'd7};
  int            seq2 [6] = '{0, 2, 3, 0, 2, 3};

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void top2(input int c, output logic [DW-1:0] t1, output logic [DW-1:0] t2,
                               output int n);
    t1 = '0; t2 = '0; n = 0;
    foreach (q_val[k]) begin
      if (q_ch[k] == c) begin
        n++;
        if (n == 1) t1 = q_val[k];
        else if (q_val[k] > t1) begin t2 = t1; t1 = q_val[k]; end
        else if (n == 2 || q_val[k] > t2) t2 = q_val[k];
      end
    end
  endfunction

  task automatic model_clear(input int c);
    int            nc [$];
    logic [DW-1:0] nv [$];
    foreach (q_ch[k]) if (q_ch[k] != c) begin nc.push_back(q_ch[k]); nv.push_back(q_val[k]); end
    q_ch = nc;
    q_val = nv;
  endtask

  task automatic model_insert(input int c, input logic [DW-1:0] v);
    bit found = 0;
    foreach (q_ch[k]) if (q_ch[k] == c && q_val[k] == v) found = 1;
    if (!found) begin q_ch.push_back(c); q_val.push_back(v); end
  endtask

  // One clock: check grant before the edge, advance model at the edge, check result just after.
  task automatic step();
    int             g;
    logic [NCH-1:0] exp_rdy;
    logic [DW-1:0]  t1, t2;
    int             n;
    @(negedge clk);
    g = -1;
    if (!reset) begin
      for (int k = 0; k < NCH; k++) begin
        int idx;
        idx = (m_rr + k) % NCH;
        if (g < 0 && req_valid[CW'(idx)]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[CW'(g)] = 1'b1;
    chk("req_ready", DW'(req_ready), DW'(exp_rdy));
    @(posedge clk);
    if (reset) begin
      m_rr = 0; q_ch.delete(); q_val.delete();
      e_vld = 0; e_ch = '0; e_max = '0; e_max2 = '0; e_ok = 0;
    end else begin
      for (int c = 0; c < NCH; c++) if (clr[CW'(c)]) model_clear(c);
      e_vld = (g >= 0);
      if (g >= 0) begin
        model_insert(g, din[CW'(g)]);
        top2(g, t1, t2, n);
        e_ch = CW'(g); e_max = t1; e_max2 = t2; e_ok = (n >= 2);
        m_rr = (g + 1) % NCH;
      end
    end
    #1;
    chk("res_valid", DW'(res_valid), DW'(e_vld));
    chk("res_ch", DW'(res_ch), DW'(e_ch));
    chk("res_max", res_max, e_max);
    chk("res_max2", res_max2, e_max2);
    chk("res_max2_ok", DW'(res_max2_ok), DW'(e_ok));
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; clr = '0;
    for (int c = 0; c < NCH; c++) din[c] = '0;
    m_rr = 0; e_vld = 0; e_ch = '0; e_max = '0; e_max2 = '0; e_ok = 0;
    #1;
    step(); step();
    chk("reset_res_valid", DW'(res_valid), 32'd0);
    chk("reset_res_max", res_max, 32'd0);
    reset = 1'b0;

    // Single channel sequence
    req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin din[0] = seq1[i]; step(); end
    chk("seq_max", res_max, 32'd9);
    chk("seq_max2", res_max2, 32'd7);
    chk("seq_ok", DW'(res_max2_ok), 32'd1);
    req_valid = '0; step();

    // Round robin from reset, then channel 1 dropped
    reset = 1'b1; step(); reset = 1'b0;
    req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < NCH; c++) din[c] = DW'($urandom_range(0, 20));
      step();
      chk("rr_all", DW'(res_ch), DW'(i % 4));
    end
    req_valid = 4'b1101;
    for (int i = 0; i < 6; i++) begin step(); chk("rr_drop1", DW'(res_ch), DW'(seq2[i])); end

    // Wrap from channel 3 to channel 0
    req_valid = 4'b1000; step();
    chk("wrap_ch3", DW'(res_ch), 32'd3);
    req_valid = 4'b0001; step();
    chk("wrap_ch0", DW'(res_ch), 32'd0);

    // Clear concurrent with a grant
    req_valid = '0; clr = 4'b0100; step(); clr = '0;
    req_valid = 4'b0100;
    din[2] = 32'd20; step();
    din[2] = 32'd10; step();
    chk("pre_clr_max", res_max, 32'd20);
    chk("pre_clr_max2", res_max2, 32'd10);
    clr = 4'b0100; din[2] = 32'd4; step(); clr = '0;
    chk("clr_grant_max", res_max, 32'd4);
    chk("clr_grant_max2", res_max2, 32'd0);
    chk("clr_grant_ok", DW'(res_max2_ok), 32'd0);
    din[2] = 32'd8; step();
    chk("after_clr_max", res_max, 32'd8);
    chk("after_clr_max2", res_max2, 32'd4);
    chk("after_clr_ok", DW'(res_max2_ok), 32'd1);

    // Boundary values on channel 1
    req_valid = '0; clr = 4'b0010; step(); clr = '0;
    req_valid = 4'b0010;
    din[1] = 32'hFFFF_FFFF; step();
    chk("bnd_max_a", res_max, 32'hFFFF_FFFF);
    chk("bnd_ok_a", DW'(res_max2_ok), 32'd0);
    din[1] = 32'h0; step();
    chk("bnd_max2_b", res_max2, 32'h0);
    chk("bnd_ok_b", DW'(res_max2_ok), 32'd1);
    din[1] = 32'hFFFF_FFFF; step();
    chk("bnd_max_c", res_max, 32'hFFFF_FFFF);
    chk("bnd_ok_c", DW'(res_max2_ok), 32'd1);

    // Reset mid-stream with all channels requesting
    req_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < NCH; c++) din[c] = DW'($urandom_range(1, 50));
      step();
    end
    reset = 1'b1; step(); reset = 1'b0;
    chk("midrst_res_valid", DW'(res_valid), 32'd0);
    din[0] = 32'd33; step();
    chk("midrst_first_ch", DW'(res_ch), 32'd0);
    chk("midrst_first_max", res_max, 32'd33);
    chk("midrst_first_ok", DW'(res_max2_ok), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      req_valid = NCH'($urandom);
      clr = ($urandom_range(0, 9) == 0) ? NCH'($urandom) : '0;
      reset = ($urandom_range(0, 99) == 0);
      for (int c = 0; c < NCH; c++)
        din[c] = ($urandom_range(0, 4) == 0) ?
                 (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h0) :
                 DW'($urandom_range(0, 12));
      step();
    end
    reset = 1'b0; req_valid = '0; clr = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
